// File: rtl/mat_loader.sv
// rtl/mat_loader.sv - stream-to-BRAM port-A writer filling the input and weight matrix BRAMs
module mat_loader #(
  parameter int WIDTH             = 16,
  parameter int CHUNK_SIZE        = 4,
  parameter int INNER_DIMENSION   = 4,
  parameter int I_OUTER_DIMENSION = 6,
  parameter int W_OUTER_DIMENSION = 6,
  parameter int ADDR_WIDTH        = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          load_sel,
  input  logic                          load_abort,
  input  logic                          clr_loaded,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WIDTH*CHUNK_SIZE-1:0]   s_data,
  input  logic                          s_last,
  output logic                          in_ena,
  output logic [7:0]                    in_wea,
  output logic [ADDR_WIDTH-1:0]         in_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]   in_dina,
  output logic                          wb_ena,
  output logic [7:0]                    wb_wea,
  output logic [ADDR_WIDTH-1:0]         wb_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]   wb_dina,
  output logic                          load_done,
  output logic                          in_loaded,
  output logic                          wb_loaded,
  output logic                          both_loaded,
  output logic                          err_last
);

  localparam int DW      = WIDTH * CHUNK_SIZE;
  localparam int WPR     = INNER_DIMENSION / CHUNK_SIZE;
  localparam int TOTAL_I = I_OUTER_DIMENSION * WPR;
  localparam int TOTAL_W = W_OUTER_DIMENSION * WPR;
  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(TOTAL_I - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(TOTAL_W - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t                state_q;
  logic                  sel_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  s_ready_q;
  logic                  in_ena_q, wb_ena_q;
  logic [7:0]            in_wea_q, wb_wea_q;
  logic [ADDR_WIDTH-1:0] in_addra_q, wb_addra_q;
  logic [DW-1:0]         in_dina_q, wb_dina_q;
  logic                  load_done_q;
  logic                  in_loaded_q, wb_loaded_q;
  logic                  err_last_q;

  logic                  hs_d;
  logic                  final_beat_d;

  // Handshake qualifier and final-beat detection for the currently selected matrix
  always_comb begin
    hs_d         = 1'b0;
    final_beat_d = 1'b0;
    if (state_q == LOAD) begin
      hs_d         = s_valid & s_ready_q;
      final_beat_d = (cnt_q == (sel_q ? LAST_W : LAST_I));
    end
  end

  // Load FSM with registered BRAM port drive, status flags and s_last checking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      cnt_q       <= '0;
      s_ready_q   <= 1'b0;
      in_ena_q    <= 1'b0;
      in_wea_q    <= '0;
      in_addra_q  <= '0;
      in_dina_q   <= '0;
      wb_ena_q    <= 1'b0;
      wb_wea_q    <= '0;
      wb_addra_q  <= '0;
      wb_dina_q   <= '0;
      load_done_q <= 1'b0;
      in_loaded_q <= 1'b0;
      wb_loaded_q <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      // Strobes are single-cycle; address and data hold between writes
      in_ena_q    <= 1'b0;
      in_wea_q    <= '0;
      wb_ena_q    <= 1'b0;
      wb_wea_q    <= '0;
      load_done_q <= 1'b0;

      // Clear first so a same-cycle flag set below takes precedence
      if (clr_loaded) begin
        in_loaded_q <= 1'b0;
        wb_loaded_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (load_start && !load_abort) begin
            state_q    <= LOAD;
            s_ready_q  <= 1'b1;
            sel_q      <= load_sel;
            cnt_q      <= '0;
            err_last_q <= 1'b0;
            if (load_sel) wb_loaded_q <= 1'b0;
            else          in_loaded_q <= 1'b0;
          end
        end

        LOAD: begin
          if (load_abort) begin
            // Any beat accepted in this cycle is dropped
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
          end else if (hs_d) begin
            if (sel_q) begin
              wb_ena_q   <= 1'b1;
              wb_wea_q   <= 8'hFF;
              wb_addra_q <= cnt_q;
              wb_dina_q  <= s_data;
            end else begin
              in_ena_q   <= 1'b1;
              in_wea_q   <= 8'hFF;
              in_addra_q <= cnt_q;
              in_dina_q  <= s_data;
            end
            cnt_q <= cnt_q + 1'b1;
            // s_last only flags a framing error; the word count alone ends the load
            if (s_last != final_beat_d) err_last_q <= 1'b1;
            if (final_beat_d) begin
              state_q     <= IDLE;
              s_ready_q   <= 1'b0;
              load_done_q <= 1'b1;
              if (sel_q) wb_loaded_q <= 1'b1;
              else       in_loaded_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign in_ena      = in_ena_q;
  assign in_wea      = in_wea_q;
  assign in_addra    = in_addra_q;
  assign in_dina     = in_dina_q;
  assign wb_ena      = wb_ena_q;
  assign wb_wea      = wb_wea_q;
  assign wb_addra    = wb_addra_q;
  assign wb_dina     = wb_dina_q;
  assign load_done   = load_done_q;
  assign in_loaded   = in_loaded_q;
  assign wb_loaded   = wb_loaded_q;
  assign both_loaded = in_loaded_q & wb_loaded_q;
  assign err_last    = err_last_q;

endmodule

// File: tb/tb_mat_loader.sv
// tb/tb_mat_loader.sv - scoreboard bench for mat_loader with a transaction-level reference model
module tb_mat_loader;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int INNER = 4;
  localparam int IO    = 6;
  localparam int WO    = 6;
  localparam int AW    = 12;
  localparam int DW    = WIDTH * CHUNK;
  localparam int TOT_I = IO * (INNER / CHUNK);
  localparam int TOT_W = WO * (INNER / CHUNK);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_start = 1'b0, load_sel = 1'b0, load_abort = 1'b0, clr_loaded = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic s_ready;
  logic in_ena, wb_ena;
  logic [7:0] in_wea, wb_wea;
  logic [AW-1:0] in_addra, wb_addra;
  logic [DW-1:0] in_dina, wb_dina;
  logic load_done, in_loaded, wb_loaded, both_loaded, err_last;

  mat_loader #(
    .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .INNER_DIMENSION(INNER),
    .I_OUTER_DIMENSION(IO), .W_OUTER_DIMENSION(WO), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_sel(load_sel),
    .load_abort(load_abort), .clr_loaded(clr_loaded), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .load_done(load_done), .in_loaded(in_loaded), .wb_loaded(wb_loaded),
    .both_loaded(both_loaded), .err_last(err_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  wq[$];
  logic done_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference model: state after the next rising edge
  bit            m_busy, m_sel, m_in_loaded, m_wb_loaded, m_err;
  int            m_cnt;
  logic [AW-1:0] m_in_addr, m_wb_addr;
  logic [DW-1:0] m_in_data, m_wb_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_busy = 0; m_sel = 0; m_in_loaded = 0; m_wb_loaded = 0; m_err = 0; m_cnt = 0;
    m_in_addr = '0; m_wb_addr = '0; m_in_data = '0; m_wb_data = '0;
  endtask

  // Drive one cycle of inputs (at a falling edge) and advance the model by one clock
  task automatic cycle(input logic st, input logic sl, input logic ab, input logic cl,
                       input logic v, input logic la, input logic [DW-1:0] d);
    int  total;
    wr_t w;
    load_start = st; load_sel = sl; load_abort = ab; clr_loaded = cl;
    s_valid = v; s_last = la; s_data = d;
    if (cl) begin m_in_loaded = 0; m_wb_loaded = 0; end
    if (!m_busy) begin
      if (st && !ab) begin
        m_busy = 1; m_sel = sl; m_cnt = 0; m_err = 0;
        if (sl) m_wb_loaded = 0; else m_in_loaded = 0;
      end
    end else if (ab) begin
      m_busy = 0;
    end else if (v) begin
      total  = m_sel ? TOT_W : TOT_I;
      w.sel  = m_sel;
      w.addr = AW'(m_cnt);
      w.data = d;
      wq.push_back(w);
      if (m_sel) begin m_wb_addr = w.addr; m_wb_data = d; end
      else       begin m_in_addr = w.addr; m_in_data = d; end
      if ((m_cnt == total - 1) != la) m_err = 1;
      m_cnt++;
      if (m_cnt == total) begin
        m_busy = 0;
        if (m_sel) m_wb_loaded = 1; else m_in_loaded = 1;
        done_q.push_back(m_sel);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    load_start = 0; load_sel = 0; load_abort = 0; clr_loaded = 0;
    s_valid = 0; s_last = 0; s_data = '0;
    model_zero();
    #1;
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_ena", 64'({in_ena, wb_ena}), 64'(0));
    chk("rst_wea", 64'({in_wea, wb_wea}), 64'(0));
    chk("rst_in_addra", 64'(in_addra), 64'(0));
    chk("rst_wb_addra", 64'(wb_addra), 64'(0));
    chk("rst_in_dina", in_dina, 64'(0));
    chk("rst_wb_dina", wb_dina, 64'(0));
    chk("rst_flags", 64'({load_done, in_loaded, wb_loaded, both_loaded, err_last}), 64'(0));
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // One load: beats numbered 1..total; last_at/abort_at/reset_at pick a beat (0 = none)
  task automatic run_load(input logic sel, input int last_at, input int abort_at,
                          input int reset_at, input bit clr_final, input bit start_mid,
                          input int gap_pct, input logic [15:0] pat, input bit use_pat,
                          input bit fixed_data);
    int total, beat;
    logic v;
    logic [DW-1:0] d;
    total = sel ? TOT_W : TOT_I;
    beat  = 0;
    cycle(1'b1, sel, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 200 && beat < total; i++) begin
      if (use_pat) v = pat[i % 16];
      else         v = ($urandom_range(99) >= gap_pct);
      if (v && beat + 1 == reset_at) begin
        do_reset();
        return;
      end
      d = fixed_data ? (64'h0001_0002_0003_0004 + 64'(beat)) : {$urandom(), $urandom()};
      cycle(v && start_mid && beat == 1, ~sel, v && beat + 1 == abort_at,
            v && clr_final && beat + 1 == total, v, v && beat + 1 == last_at, d);
      if (v) begin
        beat++;
        if (beat == abort_at) break;
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare every cycle against the model and pop the write/done scoreboards
  initial begin
    wr_t e;
    logic ds;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("s_ready", 64'(s_ready), 64'(m_busy));
        chk("in_loaded", 64'(in_loaded), 64'(m_in_loaded));
        chk("wb_loaded", 64'(wb_loaded), 64'(m_wb_loaded));
        chk("both_loaded", 64'(both_loaded), 64'(m_in_loaded & m_wb_loaded));
        chk("err_last", 64'(err_last), 64'(m_err));
        chk("in_addra", 64'(in_addra), 64'(m_in_addr));
        chk("wb_addra", 64'(wb_addra), 64'(m_wb_addr));
        chk("in_dina", in_dina, m_in_data);
        chk("wb_dina", wb_dina, m_wb_data);
        chk("write_strobe", 64'(in_ena | wb_ena), 64'(wq.size() != 0));
        if (wq.size() != 0) begin
          e = wq.pop_front();
          chk("write_port", 64'({in_ena, wb_ena}), e.sel ? 64'(1) : 64'(2));
          chk("write_addr", 64'(e.sel ? wb_addra : in_addra), 64'(e.addr));
          chk("write_data", e.sel ? wb_dina : in_dina, e.data);
          chk("write_wea", 64'({in_wea, wb_wea}), e.sel ? 64'(16'h00FF) : 64'(16'hFF00));
        end else begin
          chk("idle_wea", 64'({in_wea, wb_wea}), 64'(0));
        end
        chk("load_done", 64'(load_done), 64'(done_q.size() != 0));
        if (done_q.size() != 0) begin
          ds = done_q.pop_front();
          chk("done_with_write", 64'(ds ? wb_ena : in_ena), 64'(1));
        end
      end
    end
  end

  initial begin
    int sel, ab, lst;
    model_zero();
    #1 rst_n = 0;
    mon_en = 1'b1;
    @(negedge clk);
    do_reset();

    // Input load with the reference data pattern, back-to-back
    run_load(1'b0, TOT_I, 0, 0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b1);
    // Weight load with valid pattern 1,0,1,1,0,1,1,1
    run_load(1'b1, TOT_W, 0, 0, 1'b0, 1'b0, 0, 16'hFFED, 1'b1, 1'b0);
    // s_last on word 3 and missing on the final word
    run_load(1'b0, 3, 0, 0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run_load(1'b0, TOT_I, 0, 0, 1'b0, 1'b0, 20, 16'h0, 1'b0, 1'b0);
    // Abort together with word 4, then a fresh weight load
    run_load(1'b1, TOT_W, 4, 0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run_load(1'b1, TOT_W, 0, 0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    // clr_loaded on the final beat plus a load_start during LOAD
    run_load(1'b0, TOT_I, 0, 0, 1'b1, 1'b1, 0, 16'h0, 1'b0, 1'b0);
    // Abort beats load_start in IDLE; stray s_valid in IDLE writes nothing
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0002);
    // Reset in the middle of a load, then a new load starting at address 0
    run_load(1'b1, TOT_W, 0, 4, 1'b0, 1'b0, 0, 16'h0, 1'b0, 1'b0);
    run_load(1'b1, TOT_W, 0, 0, 1'b0, 1'b0, 30, 16'h0, 1'b0, 1'b0);

    // Randomized loads with gaps, occasional aborts, bad framing and flag clears
    for (int n = 0; n < 24; n++) begin
      sel = int'($urandom_range(1));
      ab  = ($urandom_range(3) == 0) ? int'($urandom_range(6, 1)) : 0;
      lst = ($urandom_range(4) == 0) ? int'($urandom_range(6, 1)) : 6;
      run_load(sel[0], lst, ab, 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
               int'($urandom_range(60)), 16'h0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++)
        cycle(1'b0, 1'b0, 1'b0, ($urandom_range(5) == 0), 1'($urandom_range(1)),
              1'b0, {$urandom(), $urandom()});
    end

    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("write_queue_empty", 64'(wq.size()), 64'(0));
    chk("done_queue_empty", 64'(done_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
